// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR against the TLB array and CP0; owns the Random counter.
// Writes complete 1 cycle after accept, probe/read 2 cycles; op_ready low while an op is in flight.
module tlb_op_ctrl #(
  parameter int TLB_ENTRIES = 32,
  parameter int IDX_BITS    = 5
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                op_valid,
  input  logic [1:0]          op_type,
  output logic                op_ready,
  output logic                op_done,

  input  logic [31:0]         entryHi_i,
  input  logic [31:0]         entryLo0_i,
  input  logic [31:0]         entryLo1_i,
  input  logic [31:0]         pageMask_i,
  input  logic [31:0]         index_i,
  input  logic [IDX_BITS-1:0] wired_i,
  input  logic                wired_we,

  output logic                tlb_probe_en,
  output logic [31:0]         tlb_probe_vpn,
  input  logic                tlb_probe_hit,
  input  logic [IDX_BITS-1:0] tlb_probe_idx,

  output logic                tlb_rd_en,
  output logic [IDX_BITS-1:0] tlb_rd_idx,
  input  logic [31:0]         tlb_rd_hi,
  input  logic [31:0]         tlb_rd_lo0,
  input  logic [31:0]         tlb_rd_lo1,
  input  logic [31:0]         tlb_rd_mask,

  output logic                tlb_we,
  output logic [IDX_BITS-1:0] tlb_widx,
  output logic [31:0]         tlb_wr_hi,
  output logic [31:0]         tlb_wr_lo0,
  output logic [31:0]         tlb_wr_lo1,
  output logic [31:0]         tlb_wr_mask,

  output logic                cp0_tlbr_we,
  output logic [31:0]         cp0_hi_o,
  output logic [31:0]         cp0_lo0_o,
  output logic [31:0]         cp0_lo1_o,
  output logic [31:0]         cp0_mask_o,
  output logic                cp0_tlbp_we,
  output logic [31:0]         cp0_index_o,

  output logic [31:0]         random_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0]          OP_TLBP   = 2'd0;
  localparam logic [1:0]          OP_TLBR   = 2'd1;
  localparam logic [1:0]          OP_TLBWR  = 2'd3;
  localparam logic [IDX_BITS-1:0] RAND_TOP  = IDX_BITS'(TLB_ENTRIES - 1);
  localparam logic [31:0]         MASK_BITS = 32'h1FFF_E000;
  localparam logic [31:0]         PROBE_MISS = 32'h8000_0000;

  state_t              state, state_nxt;
  logic [1:0]          op_q;
  logic [31:0]         hi_q, lo0_q, lo1_q, mask_q;
  logic [IDX_BITS-1:0] idx_q;
  logic [IDX_BITS-1:0] random_q;
  logic                accept;
  logic                wr_rand_issue;
  logic                unused_idx_hi;

  assign op_ready      = (state == S_IDLE);
  assign accept        = op_valid && op_ready;
  assign wr_rand_issue = (state == S_ISSUE) && (op_q == OP_TLBWR);
  assign random_o      = {{(32-IDX_BITS){1'b0}}, random_q};
  assign unused_idx_hi = ^index_i[31:IDX_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands are frozen at accept so CP0 updates behind us cannot corrupt the op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      hi_q   <= '0;
      lo0_q  <= '0;
      lo1_q  <= '0;
      mask_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      op_q   <= op_type;
      hi_q   <= entryHi_i;
      lo0_q  <= entryLo0_i;
      lo1_q  <= entryLo1_i;
      mask_q <= pageMask_i;
      idx_q  <= (op_type == OP_TLBWR) ? random_q : index_i[IDX_BITS-1:0];
    end
  end

  // Random never drops below Wired; a Wired write restarts it at the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      random_q <= RAND_TOP;
    end else if (wired_we) begin
      random_q <= RAND_TOP;
    end else if (wr_rand_issue) begin
      if (random_q <= wired_i) begin
        random_q <= RAND_TOP;
      end else begin
        random_q <= random_q - IDX_BITS'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    op_done       = 1'b0;
    tlb_probe_en  = 1'b0;
    tlb_probe_vpn = '0;
    tlb_rd_en     = 1'b0;
    tlb_rd_idx    = '0;
    tlb_we        = 1'b0;
    tlb_widx      = '0;
    tlb_wr_hi     = '0;
    tlb_wr_lo0    = '0;
    tlb_wr_lo1    = '0;
    tlb_wr_mask   = '0;
    cp0_tlbr_we   = 1'b0;
    cp0_hi_o      = '0;
    cp0_lo0_o     = '0;
    cp0_lo1_o     = '0;
    cp0_mask_o    = '0;
    cp0_tlbp_we   = 1'b0;
    cp0_index_o   = '0;

    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_ISSUE;
      end

      S_ISSUE: begin
        if (op_q == OP_TLBP || op_q == OP_TLBR) begin
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_IDLE;
        end
        // Strobes are suppressed while reset is high so an aborted op leaves no trace.
        if (!reset) begin
          case (op_q)
            OP_TLBP: begin
              tlb_probe_en  = 1'b1;
              tlb_probe_vpn = hi_q;
            end
            OP_TLBR: begin
              tlb_rd_en  = 1'b1;
              tlb_rd_idx = idx_q;
            end
            default: begin
              tlb_we      = 1'b1;
              tlb_widx    = idx_q;
              tlb_wr_hi   = hi_q;
              tlb_wr_lo0  = lo0_q;
              tlb_wr_lo1  = lo1_q;
              tlb_wr_mask = mask_q & MASK_BITS;
              op_done     = 1'b1;
            end
          endcase
        end
      end

      S_WAIT: begin
        state_nxt = S_IDLE;
        if (!reset) begin
          op_done = 1'b1;
          if (op_q == OP_TLBP) begin
            cp0_tlbp_we = 1'b1;
            cp0_index_o = tlb_probe_hit ? {{(32-IDX_BITS){1'b0}}, tlb_probe_idx} : PROBE_MISS;
          end else begin
            cp0_tlbr_we = 1'b1;
            cp0_hi_o    = tlb_rd_hi;
            cp0_lo0_o   = tlb_rd_lo0;
            cp0_lo1_o   = tlb_rd_lo1;
            cp0_mask_o  = tlb_rd_mask & MASK_BITS;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Multi-cycle sequencer for the privileged TLB instructions TLBP, TLBR, TLBWI and TLBWR. It sits between the execute/commit stage, the CP0 register file and the TLB array. It accepts one committed TLB operation at a time and stalls further requests while busy. It drives the TLB array's probe, read and write ports, returns results to CP0 as write-enable pulses, and owns the Random counter used by TLBWR.

## Interface
- `TLB_ENTRIES`, default 32: number of TLB entries; must be a power of two, at least 2.
- `IDX_BITS`, default 5: log2(`TLB_ENTRIES`).
- `clk` in 1: the single clock; everything is sampled on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `op_valid` in 1: a committed TLB instruction is presented.
- `op_type` in 2: 0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR.
- `op_ready` out 1: block is idle and accepts an op this cycle.
- `op_done` out 1: one-cycle pulse when the op has completed.
- `entryHi_i`, `entryLo0_i`, `entryLo1_i`, `pageMask_i`, `index_i` in 32 each: current CP0 register values.
- `wired_i` in `IDX_BITS`: CP0 Wired value.
- `wired_we` in 1: CP0 Wired register is being written this cycle.
- `tlb_probe_en` out 1: probe request.
- `tlb_probe_vpn` out 32: EntryHi value to probe with.
- `tlb_probe_hit` in 1 and `tlb_probe_idx` in `IDX_BITS`: probe result, valid one cycle after `tlb_probe_en`.
- `tlb_rd_en` out 1 and `tlb_rd_idx` out `IDX_BITS`: read request.
- `tlb_rd_hi`, `tlb_rd_lo0`, `tlb_rd_lo1`, `tlb_rd_mask` in 32 each: read data, valid one cycle after `tlb_rd_en`.
- `tlb_we` out 1 and `tlb_widx` out `IDX_BITS`: write request and target index.
- `tlb_wr_hi`, `tlb_wr_lo0`, `tlb_wr_lo1`, `tlb_wr_mask` out 32 each: write data.
- `cp0_tlbr_we` out 1: load the four CP0 TLB registers from `cp0_hi_o`, `cp0_lo0_o`, `cp0_lo1_o`, `cp0_mask_o` (out 32 each).
- `cp0_tlbp_we` out 1: load CP0 Index from `cp0_index_o` (out 32).
- `random_o` out 32: Random register value; bits [31:`IDX_BITS`] are always 0.

## Operation
- States are IDLE, ISSUE and WAIT.
- `op_ready` = (state == IDLE).
- Accept: `op_valid && op_ready`. On the accept edge the block latches `op_type`, all five CP0 inputs, and the target index:
  - `index_i[IDX_BITS-1:0]` for TLBR and TLBWI;
  - `random_o` for TLBWR.
- IDLE -> ISSUE on accept. In ISSUE the block drives exactly one TLB port:
  - TLBP: `tlb_probe_en`=1, `tlb_probe_vpn` = latched EntryHi.
  - TLBR: `tlb_rd_en`=1, `tlb_rd_idx` = latched index.
  - TLBWI and TLBWR: `tlb_we`=1, `tlb_widx` = latched index.
    - Write data = latched EntryHi, EntryLo0, EntryLo1, and PageMask & 32'h1FFF_E000.
    - `op_done`=1 in this cycle, then ISSUE -> IDLE.
- TLBP and TLBR go ISSUE -> WAIT. In WAIT, `op_done`=1, then WAIT -> IDLE.
  - TLBP in WAIT: `cp0_tlbp_we`=1.
    - `cp0_index_o` = {27'b0, `tlb_probe_idx`} (zero-extended) on a hit.
    - `cp0_index_o` = 32'h8000_0000 (P bit set, index 0) on a miss.
  - TLBR in WAIT: `cp0_tlbr_we`=1.
    - `cp0_hi_o`, `cp0_lo0_o`, `cp0_lo1_o` = the corresponding read data, passed through.
    - `cp0_mask_o` = `tlb_rd_mask` & 32'h1FFF_E000.
- Outside their asserting state, all strobes are 0. All data outputs are don't-care when their strobe is low, but must be deterministic.
- Random counter:
  - Reset value `TLB_ENTRIES`-1.
  - Updates only when a TLBWR write is issued: if random == `wired_i` or random < `wired_i`, next = `TLB_ENTRIES`-1; otherwise next = random-1.
  - `wired_we` forces random to `TLB_ENTRIES`-1. This has priority over a simultaneous TLBWR update; the write still uses the old latched random.
- `op_valid` is ignored while not IDLE. No abort exists: an accepted op always completes unless `reset` is asserted.

## Timing
- Accept at edge T:
  - TLBWI/TLBWR: `tlb_we` and `op_done` in cycle T+1; `op_ready` high again in T+2.
  - TLBP/TLBR: port strobe in T+1; CP0 writeback strobe and `op_done` in T+2; `op_ready` high in T+3.
- Back-to-back throughput: one write op per 2 cycles; one probe/read op per 3 cycles.
- Reset, from any state, on the reset edge:
  - state = IDLE, random = `TLB_ENTRIES`-1;
  - all strobes and `op_done` = 0; `op_ready` = 1;
  - all data outputs = 0; `random_o` = `TLB_ENTRIES`-1.
- Reset asserted during ISSUE or WAIT: no further TLB or CP0 strobes are produced for the aborted op.
- CP0 inputs changing after accept have no effect on the op in flight.

## Test plan
- Reset, then TLBWR with `wired_i`=4, three times:
  - `tlb_widx` = 31, 30, 29, each with `op_done` at T+1;
  - `random_o` ends at 28.
- Walk random down to 4 (`wired_i`=4), then TLBWR:
  - write uses index 4;
  - `random_o` wraps to 31.
- TLBP with `entryHi_i`=32'h1234_6000:
  - hit with idx 7: `cp0_tlbp_we` at T+2 with `cp0_index_o`=32'h0000_0007;
  - miss: `cp0_index_o`=32'h8000_0000.
- TLBR with `index_i`=32'hFFFF_FFE9:
  - `tlb_rd_idx`=9 at T+1;
  - read mask 32'hFFFF_FFFF gives `cp0_mask_o`=32'h1FFF_E000 at T+2;
  - other three words are passed through.
- Hold `op_valid` high with alternating TLBP/TLBWI:
  - accepts occur only when `op_ready` is high;
  - `op_done` spacing is 3 cycles after a TLBP and 2 after a TLBWI;
  - there is never more than one port strobe per cycle.
- `wired_we` in the same cycle as a TLBWR write at random 20:
  - write index 20;
  - `random_o` = 31.
- Separately, reset asserted in WAIT of a TLBR:
  - no `cp0_tlbr_we` pulse;
  - `op_ready`=1 on the next cycle.
